// File: rtl/hue_wheel_pkg.sv
// Shared types and the sector-to-RGB intensity mapping for the hue wheel driver.
// Intensities are carried at MAP_W bits; callers narrow them to their PWM width.
package hue_wheel_pkg;

    localparam int SECTORS = 6;
    localparam int MAP_W   = 16;

    typedef enum logic [2:0] {
        RED_S     = 3'd0,
        YELLOW_S  = 3'd1,
        GREEN_S   = 3'd2,
        CYAN_S    = 3'd3,
        BLUE_S    = 3'd4,
        MAGENTA_S = 3'd5
    } sector_t;

    typedef struct packed {
        logic [MAP_W-1:0] r;
        logic [MAP_W-1:0] g;
        logic [MAP_W-1:0] b;
    } rgb_t;

    // Each sector ramps exactly one channel up or down while the others sit at 0 or MAX.
    function automatic rgb_t sector_rgb(input sector_t          sector,
                                        input logic [MAP_W-1:0] level,
                                        input logic [MAP_W-1:0] max_val);
        rgb_t             rgb;
        logic [MAP_W-1:0] dn;
        logic [MAP_W-1:0] zero;
        zero = '0;
        dn   = max_val - level;
        rgb  = '0;
        case (sector)
            RED_S:     rgb = {max_val, level,   zero};
            YELLOW_S:  rgb = {dn,      max_val, zero};
            GREEN_S:   rgb = {zero,    max_val, level};
            CYAN_S:    rgb = {zero,    dn,      max_val};
            BLUE_S:    rgb = {level,   zero,    max_val};
            MAGENTA_S: rgb = {max_val, zero,    dn};
            default:   rgb = '0;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: frame-start duty latch, counter compare and registered pin.
// The compare bypasses the latch at frame start so every frame uses one duty value.
module pwm_channel #(
    parameter int PWM_BITS   = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] intensity,
    output logic                pin
);

    localparam logic OFF_LVL = (ACTIVE_LOW != 0);

    logic [PWM_BITS-1:0] r_duty;
    logic                r_pin;
    logic [PWM_BITS-1:0] w_duty;
    logic                w_on;

    assign w_duty = frame_start ? intensity : r_duty;
    assign w_on   = (pwm_cnt < w_duty);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_duty <= '0;
            r_pin  <= OFF_LVL;
        end else begin
            if (frame_start) begin
                r_duty <= intensity;
            end
            r_pin <= w_on ? ~OFF_LVL : OFF_LVL;
        end
    end

    assign pin = r_pin;

endmodule

// File: rtl/hue_wheel_pwm.sv
// RGB colour-wheel driver: walks the hue circle (smooth fade or six-colour steps)
// and drives three PWM pins. Define HUE_WHEEL_BRIGHTNESS_EN to add a global brightness input.
module hue_wheel_pwm
    import hue_wheel_pkg::*;
#(
    parameter int STEP_CYCLES = 2000,
    parameter int PWM_BITS    = 8,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                step_mode,
`ifdef HUE_WHEEL_BRIGHTNESS_EN
    input  logic [PWM_BITS-1:0] brightness,
`endif
    output logic [2:0]          hue_sector,
    output logic [PWM_BITS-1:0] hue_level,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B
);

    localparam int                  SCW       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SCW-1:0]      STEP_LAST = SCW'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [SCW-1:0]      r_step_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [2:0]          r_sector;
    logic [PWM_BITS-1:0] r_level;

    logic                w_tick;
    logic                w_frame_start;
    logic [2:0]          w_sector_inc;
    logic [PWM_BITS-1:0] w_map_level;
    rgb_t                w_rgb;
    logic [PWM_BITS-1:0] w_intensity [3];
    logic [PWM_BITS-1:0] w_duty_in   [3];
    logic                w_pin       [3];

    assign w_tick        = (r_step_cnt == STEP_LAST);
    assign w_frame_start = (r_pwm_cnt == '0);
    assign w_sector_inc  = (r_sector == 3'(SECTORS - 1)) ? 3'd0 : r_sector + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_step_cnt <= w_tick ? '0 : r_step_cnt + SCW'(1);
            r_pwm_cnt  <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + PWM_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sector <= 3'd0;
            r_level  <= '0;
        end else if (w_tick && en) begin
            if (step_mode || (r_level == MAX)) begin
                r_sector <= w_sector_inc;
                r_level  <= '0;
            end else begin
                r_level <= r_level + PWM_BITS'(1);
            end
        end
    end

    // Step mode shows the pure sector colour even while a stale fade level is still held.
    assign w_map_level = step_mode ? '0 : r_level;
    assign w_rgb       = sector_rgb(sector_t'(r_sector), MAP_W'(w_map_level), MAP_W'(MAX));

    assign w_intensity[0] = PWM_BITS'(w_rgb.r);
    assign w_intensity[1] = PWM_BITS'(w_rgb.g);
    assign w_intensity[2] = PWM_BITS'(w_rgb.b);

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
`ifdef HUE_WHEEL_BRIGHTNESS_EN
        localparam int PROD_W = 2 * PWM_BITS + 1;
        logic [PROD_W-1:0] w_scaled;
        assign w_scaled      = PROD_W'(w_intensity[gi]) * (PROD_W'(brightness) + PROD_W'(1));
        assign w_duty_in[gi] = PWM_BITS'(w_scaled >> PWM_BITS);
`else
        assign w_duty_in[gi] = w_intensity[gi];
`endif
        pwm_channel #(
            .PWM_BITS   (PWM_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .frame_start (w_frame_start),
            .pwm_cnt     (r_pwm_cnt),
            .intensity   (w_duty_in[gi]),
            .pin         (w_pin[gi])
        );
    end

    assign hue_sector = r_sector;
    assign hue_level  = r_level;
    assign RGB_R      = w_pin[0];
    assign RGB_G      = w_pin[1];
    assign RGB_B      = w_pin[2];

endmodule

// File: tb/tb_hue_wheel_pwm.sv
// Self-checking bench for hue_wheel_pwm (STEP_CYCLES=4, PWM_BITS=3, ACTIVE_LOW=1).
// The reference model tracks hue as a position on the wheel and derives channel levels geometrically.
module tb_hue_wheel_pwm;

    localparam int STEP = 4;
    localparam int PB   = 3;
    localparam int MAXV = 7;
    localparam int ALOW = 1;
    localparam int NPOS = 6 * (MAXV + 1);

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          step_mode;
`ifdef HUE_WHEEL_BRIGHTNESS_EN
    logic [PB-1:0] brightness;
`endif
    logic [2:0]    hue_sector;
    logic [PB-1:0] hue_level;
    logic          RGB_R;
    logic          RGB_G;
    logic          RGB_B;

    int n_checks = 0;
    int n_fail   = 0;

    int         m_n;
    int         m_pos;
    int         m_duty [3];
    logic [2:0] m_pins;

    hue_wheel_pwm #(
        .STEP_CYCLES (STEP),
        .PWM_BITS    (PB),
        .ACTIVE_LOW  (ALOW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .step_mode  (step_mode),
`ifdef HUE_WHEEL_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .hue_sector (hue_sector),
        .hue_level  (hue_level),
        .RGB_R      (RGB_R),
        .RGB_G      (RGB_G),
        .RGB_B      (RGB_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Channel c peaks at hue angle c*120 degrees: full within one sector of the peak,
    // linear ramp over the next sector, dark beyond.
    function automatic int chan_int(input int c, input int sector, input int level);
        int p, x, diff, d;
        p    = 6 * MAXV;
        x    = sector * MAXV + level;
        diff = ((x - c * 2 * MAXV) % p + p) % p;
        d    = (diff < p - diff) ? diff : p - diff;
        if (d <= MAXV) return MAXV;
        if (d >= 2 * MAXV) return 0;
        return 2 * MAXV - d;
    endfunction

    function automatic int scale(input int i);
`ifdef HUE_WHEEL_BRIGHTNESS_EN
        return (i * (int'(brightness) + 1)) >> PB;
`else
        return i;
`endif
    endfunction

    function automatic logic [8:0] model_vec();
        return {3'(m_pos / (MAXV + 1)), 3'(m_pos % (MAXV + 1)), m_pins};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {hue_sector, hue_level, RGB_R, RGB_G, RGB_B};
    endfunction

    // Advance one clock; the model consumes the same inputs the DUT saw at the edge.
    task automatic cyc();
        int ph;
        @(posedge clk);
        if (!rst_n) begin
            m_n    = 0;
            m_pos  = 0;
            m_duty = '{0, 0, 0};
            m_pins = 3'b111;
        end else begin
            ph = m_n % MAXV;
            if (ph == 0) begin
                for (int c = 0; c < 3; c++)
                    m_duty[c] = scale(chan_int(c, m_pos / (MAXV + 1),
                                               step_mode ? 0 : m_pos % (MAXV + 1)));
            end
            for (int c = 0; c < 3; c++)
                m_pins[2-c] = ((ph < m_duty[c]) ? 1'b1 : 1'b0) ^ (ALOW != 0);
            if (en && (m_n % STEP == STEP - 1))
                m_pos = step_mode ? (((m_pos / (MAXV + 1)) + 1) % 6) * (MAXV + 1)
                                  : (m_pos + 1) % NPOS;
            m_n++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; step_mode = 1'b0;
        repeat (3) cyc();
        n_checks++;
        if (dut_vec() !== 9'b000_000_111) begin
            n_fail++;
            $display("FAIL reset_state: got %b required %b", dut_vec(), 9'b000_000_111);
        end
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if (dut_vec() !== 9'b000_000_011) begin
            n_fail++;
            $display("FAIL first_frame_red: got %b required %b", dut_vec(), 9'b000_000_011);
        end
    endtask

    task automatic test_smooth();
        do_reset();
        en = 1'b1; step_mode = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            cyc();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL smooth_cycle %0d: got %b required %b", i, dut_vec(), model_vec());
            end
            if (i == 4 || i == 32 || i == 188 || i == 192) begin
                n_checks++;
                if ({hue_sector, hue_level} !== ((i == 4)   ? 6'o01 :
                                                 (i == 32)  ? 6'o10 :
                                                 (i == 188) ? 6'o57 : 6'o00)) begin
                    n_fail++;
                    $display("FAIL smooth_milestone %0d: got sector %0d level %0d",
                             i, hue_sector, hue_level);
                end
            end
        end
    endtask

    task automatic test_step();
        int exp_on [6][3] = '{'{7,0,0}, '{7,7,0}, '{0,7,0}, '{0,7,7}, '{0,0,7}, '{7,0,7}};
        int on [3];
        int guard;
        logic [2:0] pins;
        do_reset();
        en = 1'b1; step_mode = 1'b1;
        for (int s = 0; s < 6; s++) begin
            guard = 0;
            en = 1'b1;
            while ((m_pos / (MAXV + 1) != s) && guard < 40) begin
                cyc();
                guard++;
                n_checks++;
                if (dut_vec() !== model_vec()) begin
                    n_fail++;
                    $display("FAIL step_advance s%0d: got %b required %b", s, dut_vec(), model_vec());
                end
            end
            en = 1'b0;
            while (m_n % MAXV != 0) cyc();
            on = '{0, 0, 0};
            for (int k = 0; k < MAXV; k++) begin
                cyc();
                pins = {RGB_R, RGB_G, RGB_B};
                for (int c = 0; c < 3; c++) if (pins[2-c] == 1'b0) on[c]++;
            end
            n_checks++;
            if (on[0] != exp_on[s][0] || on[1] != exp_on[s][1] || on[2] != exp_on[s][2]
                || hue_sector !== 3'(s) || hue_level !== '0) begin
                n_fail++;
                $display("FAIL step_colour s%0d: got on=%0d/%0d/%0d sector %0d level %0d required %0d/%0d/%0d",
                         s, on[0], on[1], on[2], hue_sector, hue_level,
                         exp_on[s][0], exp_on[s][1], exp_on[s][2]);
            end
        end
    endtask

    task automatic test_level3();
        int on [3];
        int guard;
        logic [2:0] pins;
        do_reset();
        en = 1'b1; step_mode = 1'b0;
        guard = 0;
        while (m_pos != 3 && guard < 40) begin cyc(); guard++; end
        en = 1'b0;
        while (m_n % MAXV != 0) cyc();
        on = '{0, 0, 0};
        for (int k = 0; k < MAXV; k++) begin
            cyc();
            pins = {RGB_R, RGB_G, RGB_B};
            for (int c = 0; c < 3; c++) if (pins[2-c] == 1'b0) on[c]++;
        end
        n_checks++;
        if (on[0] != 7 || on[1] != 3 || on[2] != 0) begin
            n_fail++;
            $display("FAIL level3_duty: got low counts %0d/%0d/%0d required 7/3/0", on[0], on[1], on[2]);
        end
    endtask

    task automatic test_freeze();
        int guard;
        do_reset();
        en = 1'b1; step_mode = 1'b0;
        guard = 0;
        while (m_pos != 19 && guard < 200) begin cyc(); guard++; end
        en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            n_checks++;
            if (dut_vec() !== model_vec() || hue_sector !== 3'd2 || hue_level !== 3'd3) begin
                n_fail++;
                $display("FAIL freeze_hold %0d: got %b required %b", i, dut_vec(), model_vec());
            end
        end
        en = 1'b1;
        repeat (STEP) cyc();
        n_checks++;
        if (hue_sector !== 3'd2 || hue_level !== 3'd4) begin
            n_fail++;
            $display("FAIL freeze_resume: got sector %0d level %0d required 2 4", hue_sector, hue_level);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int on_r, on_g;
        do_reset();
        en = 1'b1; step_mode = 1'b0;
        guard = 0;
        while (m_pos != 34 && guard < 200) begin cyc(); guard++; end
        rst_n = 1'b0;
        cyc();
        n_checks++;
        if (dut_vec() !== 9'b000_000_111) begin
            n_fail++;
            $display("FAIL reset_mid_state: got %b required %b", dut_vec(), 9'b000_000_111);
        end
        rst_n = 1'b1;
        on_r = 0; on_g = 0;
        for (int k = 0; k < MAXV; k++) begin
            cyc();
            if (RGB_R == 1'b0) on_r++;
            if (RGB_G == 1'b0) on_g++;
        end
        n_checks++;
        if (on_r != 7 || on_g != 0) begin
            n_fail++;
            $display("FAIL reset_mid_red: got R on %0d G on %0d required 7 0", on_r, on_g);
        end
    endtask

    task automatic test_random();
        do_reset();
        en = 1'b1; step_mode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
            rst_n = ($urandom_range(0, 149) != 0);
            cyc();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle %0d: got %b required %b", i, dut_vec(), model_vec());
            end
        end
        rst_n = 1'b1;
    endtask

`ifdef HUE_WHEEL_BRIGHTNESS_EN
    task automatic test_brightness();
        int on_r;
        int exp_r [4] = '{3, 7, 7, 3};
        do_reset();
        en = 1'b0; step_mode = 1'b1;
        for (int f = 0; f < 4; f++) begin
            brightness = (f == 0 || f == 3) ? 3'd3 : 3'd7;
            on_r = 0;
            for (int k = 0; k < MAXV; k++) begin
                if (f == 2 && k == 3) brightness = 3'd3;
                cyc();
                if (RGB_R == 1'b0) on_r++;
                n_checks++;
                if (dut_vec() !== model_vec()) begin
                    n_fail++;
                    $display("FAIL bright_cycle f%0d k%0d: got %b required %b", f, k, dut_vec(), model_vec());
                end
            end
            n_checks++;
            if (on_r != exp_r[f]) begin
                n_fail++;
                $display("FAIL bright_duty f%0d: got %0d required %0d", f, on_r, exp_r[f]);
            end
        end
        brightness = 3'd7;
    endtask
`endif

    initial begin
        rst_n = 1'b0; en = 1'b0; step_mode = 1'b0;
`ifdef HUE_WHEEL_BRIGHTNESS_EN
        brightness = 3'd7;
`endif
        m_n = 0; m_pos = 0; m_duty = '{0, 0, 0}; m_pins = 3'b111;
        @(negedge clk);
        test_reset();
        test_smooth();
        test_step();
        test_level3();
        test_freeze();
        test_reset_mid();
        test_random();
`ifdef HUE_WHEEL_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
